// File: rtl/rvh_l1d_bank_wb_axi_master.sv
// Per-bank L1D writeback AXI write master.
// Evicted dirty lines are queued in a small line FIFO. The head line is sent
// as one INCR burst (AW + W), and is popped when its B response arrives.
// Optional macro L1D_WB_BRESP_CHECK_EN: an error B response sets a sticky wb_err.
module rvh_l1d_bank_wb_axi_master #(
   parameter int unsigned PADDR_WIDTH = 56,
   parameter int unsigned LINE_BYTES  = 64,
   parameter int unsigned BUS_BYTES   = 32,
   parameter int unsigned WB_DEPTH    = 2,
   parameter int unsigned ID_WIDTH    = 8,
   parameter int unsigned BANK_ID     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_req_valid,
   output logic                      wb_req_ready,
   input  logic [PADDR_WIDTH-1:0]    wb_req_paddr,
   input  logic [LINE_BYTES*8-1:0]   wb_req_data,
   input  logic [PADDR_WIDTH-1:0]    probe_paddr,
   output logic                      probe_hit,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [PADDR_WIDTH-1:0]    awaddr,
   output logic [ID_WIDTH-1:0]       awid,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic                      wvalid,
   input  logic                      wready,
   output logic [BUS_BYTES*8-1:0]    wdata,
   output logic [BUS_BYTES-1:0]      wstrb,
   output logic                      wlast,
   input  logic                      bvalid,
   output logic                      bready,
   input  logic [1:0]                bresp,
   output logic                      wb_busy,
   output logic                      wb_err
);

   localparam int unsigned BEATS  = LINE_BYTES / BUS_BYTES;
   localparam int unsigned LINE_W = LINE_BYTES * 8;
   localparam int unsigned BUS_W  = BUS_BYTES * 8;
   localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
   localparam int unsigned TAG_W  = PADDR_WIDTH - OFF_W;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned PTR_W  = $clog2(WB_DEPTH);
   localparam int unsigned CNT_W  = $clog2(WB_DEPTH + 1);
   localparam int unsigned SIZE   = $clog2(BUS_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_WAIT_B = 2'd2
   } state_t;

   state_t              state;
   logic [BEAT_W-1:0]   beat;
   logic                aw_done;
   logic                w_done;

   logic [TAG_W-1:0]    tag_mem  [WB_DEPTH];
   logic [LINE_W-1:0]   data_mem [WB_DEPTH];
   logic [WB_DEPTH-1:0] vld;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;

   logic push;
   logic pop;
   logic aw_hs;
   logic w_hs;
   logic last_beat;
   logic aw_fin;
   logic w_fin;

   assign wb_req_ready = (count != CNT_W'(WB_DEPTH));
   assign push         = wb_req_valid & wb_req_ready;
   assign pop          = (state == ST_WAIT_B) & bvalid;

   assign awvalid   = (state == ST_SEND) & ~aw_done;
   assign wvalid    = (state == ST_SEND) & ~w_done;
   assign bready    = (state == ST_WAIT_B);
   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   assign last_beat = (beat == BEAT_W'(BEATS - 1));
   assign aw_fin    = aw_done | aw_hs;
   assign w_fin     = w_done | (w_hs & last_beat);

   // AXI burst fields; head entry cannot change until its B handshake, so these are stable
   assign awaddr  = {tag_mem[rd_ptr], OFF_W'(0)};
   assign awid    = ID_WIDTH'(BANK_ID);
   assign awlen   = 8'(BEATS - 1);
   assign awsize  = 3'(SIZE);
   assign awburst = 2'b01;
   assign wdata   = data_mem[rd_ptr][beat*BUS_W +: BUS_W];
   assign wstrb   = '1;
   assign wlast   = last_beat;
   assign wb_busy = (count != '0) | (state != ST_IDLE);

   // Line payload storage, written on push
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr]  <= wb_req_paddr[PADDR_WIDTH-1:OFF_W];
         data_mem[wr_ptr] <= wb_req_data;
      end
   end

   // FIFO pointers, occupancy and per-entry valid bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (push) begin
            wr_ptr      <= wr_ptr + PTR_W'(1);
            vld[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + PTR_W'(1);
            vld[rd_ptr] <= 1'b0;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Burst FSM: one outstanding burst, AW and W issued together, then wait for B
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         beat    <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((count != '0) || push) begin
                  state   <= ST_SEND;
                  beat    <= '0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            ST_SEND: begin
               aw_done <= aw_fin;
               w_done  <= w_fin;
               if (w_hs && !last_beat) begin
                  beat <= beat + BEAT_W'(1);
               end
               if (aw_fin && w_fin) begin
                  state <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (bvalid) begin
                  state   <= ((count > CNT_W'(1)) || push) ? ST_SEND : ST_IDLE;
                  beat    <= '0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Address probe against every queued line, including the one in flight
   always_comb begin
      probe_hit = 1'b0;
      for (int i = 0; i < int'(WB_DEPTH); i++) begin
         if (vld[i] && (tag_mem[i] == probe_paddr[PADDR_WIDTH-1:OFF_W])) begin
            probe_hit = 1'b1;
         end
      end
   end

`ifdef L1D_WB_BRESP_CHECK_EN
   logic err_q;

   // Sticky error on SLVERR/DECERR; the line is still retired
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (pop && bresp[1]) begin
         err_q <= 1'b1;
      end
   end

   assign wb_err = err_q;
`else
   assign wb_err = 1'b0;
`endif

   // Line-offset address bits and unchecked response bits are intentionally ignored
   logic unused_bits;
   assign unused_bits = ^{wb_req_paddr[OFF_W-1:0], probe_paddr[OFF_W-1:0], bresp};

endmodule

// File: tb/tb_rvh_l1d_bank_wb_axi_master.sv
// Self-checking bench for rvh_l1d_bank_wb_axi_master (default parameters).
// Honors L1D_WB_BRESP_CHECK_EN for the expected wb_err behaviour.
module tb_rvh_l1d_bank_wb_axi_master;

   localparam int unsigned PW    = 56;
   localparam int unsigned BEATS = 2;
   localparam int unsigned DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            wb_req_valid;
   logic            wb_req_ready;
   logic [PW-1:0]   wb_req_paddr;
   logic [511:0]    wb_req_data;
   logic [PW-1:0]   probe_paddr;
   logic            probe_hit;
   logic            awvalid;
   logic            awready;
   logic [PW-1:0]   awaddr;
   logic [7:0]      awid;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            wvalid;
   logic            wready;
   logic [255:0]    wdata;
   logic [31:0]     wstrb;
   logic            wlast;
   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic            wb_busy;
   logic            wb_err;

   rvh_l1d_bank_wb_axi_master dut (
      .clk          (clk),
      .rst          (rst),
      .wb_req_valid (wb_req_valid),
      .wb_req_ready (wb_req_ready),
      .wb_req_paddr (wb_req_paddr),
      .wb_req_data  (wb_req_data),
      .probe_paddr  (probe_paddr),
      .probe_hit    (probe_hit),
      .awvalid      (awvalid),
      .awready      (awready),
      .awaddr       (awaddr),
      .awid         (awid),
      .awlen        (awlen),
      .awsize       (awsize),
      .awburst      (awburst),
      .wvalid       (wvalid),
      .wready       (wready),
      .wdata        (wdata),
      .wstrb        (wstrb),
      .wlast        (wlast),
      .bvalid       (bvalid),
      .bready       (bready),
      .bresp        (bresp),
      .wb_busy      (wb_busy),
      .wb_err       (wb_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // responder configuration (written by the main sequence only)
   int         aw_stall_cfg = 0;
   bit         w_alt        = 1'b0;
   int         b_delay      = 3;
   logic [1:0] b_resp_cfg   = 2'b00;

   // responder state
   int aw_wait_cnt = 0;
   int b_cnt       = 0;

   // AXI slave responder: driven just after each rising edge
   always @(posedge clk) begin
      #1;
      if (rst) begin
         awready     = 1'b0;
         wready      = 1'b0;
         bvalid      = 1'b0;
         bresp       = 2'b00;
         aw_wait_cnt = 0;
         b_cnt       = 0;
      end else begin
         if (!awvalid) aw_wait_cnt = 0;
         else if (!awready) aw_wait_cnt++;
         awready = awvalid ? (aw_wait_cnt >= aw_stall_cfg) : (aw_stall_cfg == 0);
         wready  = w_alt ? ~wready : 1'b1;
         if (bvalid) begin
            bvalid = 1'b0;
            b_cnt  = 0;
         end else if (bready) begin
            if (b_cnt >= b_delay) begin
               bvalid = 1'b1;
               bresp  = b_resp_cfg;
            end else begin
               b_cnt++;
            end
         end
      end
   end

   // scoreboard and reference model state (written by the monitor only)
   logic [PW-1:0]  pend_q[$];
   logic [PW-1:0]  aw_q[$];
   logic [511:0]   w_q[$];
   int             w_beat       = 0;
   bit             aw_done_cur  = 1'b0;
   bit             w_done_cur   = 1'b0;
   bit             w_first_seen = 1'b0;
   bit             model_err    = 1'b0;
   bit             prev_aw_stall = 1'b0;
   logic [PW-1:0]  prev_awaddr  = '0;
   int             b_count      = 0;

   // Monitor: checks outputs against the model on the falling edge, then applies handshakes
   always @(negedge clk) begin
      if (rst) begin
         pend_q.delete();
         aw_q.delete();
         w_q.delete();
         w_beat        = 0;
         aw_done_cur   = 1'b0;
         w_done_cur    = 1'b0;
         model_err     = 1'b0;
         prev_aw_stall = 1'b0;
      end else begin
         logic          hit;
         logic [PW-1:0] a;
         logic [511:0]  d;
         hit = 1'b0;
         foreach (pend_q[i]) if (pend_q[i][PW-1:6] == probe_paddr[PW-1:6]) hit = 1'b1;
         chk("req_ready", 512'(wb_req_ready), 512'(pend_q.size() < DEPTH));
         chk("wb_busy",   512'(wb_busy),      512'(pend_q.size() != 0));
         chk("probe_hit", 512'(probe_hit),    512'(hit));
         chk("wb_err",    512'(wb_err),       512'(model_err));
         if (prev_aw_stall && awvalid) chk("awaddr_stable", 512'(awaddr), 512'(prev_awaddr));
         if (w_done_cur && !aw_done_cur) begin
            chk("wvalid_drop", 512'(wvalid), 512'(0));
            if (awvalid) w_first_seen = 1'b1;
         end
         if (bready) chk("bready_order", 512'(aw_done_cur && w_done_cur), 512'(1));

         if (awvalid && awready) begin
            if (aw_q.size() == 0) begin
               chk("aw_unexpected", 512'(1), 512'(0));
            end else begin
               a = aw_q.pop_front();
               chk("awaddr",  512'(awaddr),  512'(a));
               chk("awlen",   512'(awlen),   512'(BEATS - 1));
               chk("awsize",  512'(awsize),  512'(5));
               chk("awburst", 512'(awburst), 512'(1));
               chk("awid",    512'(awid),    512'(0));
            end
            aw_done_cur = 1'b1;
         end
         if (wvalid && wready) begin
            if (w_q.size() == 0) begin
               chk("w_unexpected", 512'(1), 512'(0));
            end else begin
               d = w_q[0];
               chk("wdata", 512'(wdata), 512'(d[w_beat*256 +: 256]));
               chk("wlast", 512'(wlast), 512'(w_beat == BEATS - 1));
               chk("wstrb", 512'(wstrb), 512'(32'hFFFF_FFFF));
               if (w_beat == BEATS - 1) begin
                  void'(w_q.pop_front());
                  w_beat     = 0;
                  w_done_cur = 1'b1;
               end else begin
                  w_beat++;
               end
            end
         end
         prev_aw_stall = awvalid && !awready;
         prev_awaddr   = awaddr;

         if (bvalid && bready) begin
`ifdef L1D_WB_BRESP_CHECK_EN
            if (bresp[1]) model_err = 1'b1;
`endif
            if (pend_q.size() != 0) void'(pend_q.pop_front());
            aw_done_cur = 1'b0;
            w_done_cur  = 1'b0;
            b_count++;
         end
         if (wb_req_valid && wb_req_ready) begin
            a = {wb_req_paddr[PW-1:6], 6'd0};
            pend_q.push_back(a);
            aw_q.push_back(a);
            w_q.push_back(wb_req_data);
         end
      end
   end

   function automatic logic [511:0] rand_line();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Offer one line; returns just after the rising edge that accepted it
   task automatic push_line(input logic [PW-1:0] a, input logic [511:0] d);
      int t;
      t = 0;
      wb_req_valid = 1'b1;
      wb_req_paddr = a;
      wb_req_data  = d;
      @(negedge clk);
      while (!wb_req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("push_timeout", 512'(1), 512'(0));
      @(posedge clk);
      #1;
      wb_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (wb_busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk("idle_timeout", 512'(1), 512'(0));
   endtask

   task automatic wait_b_hs();
      int t;
      t = 0;
      @(negedge clk);
      while (!(bvalid && bready) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("b_timeout", 512'(1), 512'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int b_before;
      int stray;
      logic exp_err;
      rst          = 1'b1;
      wb_req_valid = 1'b0;
      wb_req_paddr = '0;
      wb_req_data  = '0;
      probe_paddr  = '0;
      repeat (3) @(negedge clk);
      chk("rst_awvalid",   512'(awvalid),      512'(0));
      chk("rst_wvalid",    512'(wvalid),       512'(0));
      chk("rst_bready",    512'(bready),       512'(0));
      chk("rst_busy",      512'(wb_busy),      512'(0));
      chk("rst_err",       512'(wb_err),       512'(0));
      chk("rst_probe",     512'(probe_hit),    512'(0));
      chk("rst_req_ready", 512'(wb_req_ready), 512'(1));
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // single line, full-speed channels, B three cycles after bready
      probe_paddr = 56'h8000_107F;
      push_line(56'h8000_1040, rand_line());
      @(negedge clk);
      chk("t1_awvalid_lat", 512'(awvalid),   512'(1));
      chk("t1_wvalid_lat",  512'(wvalid),    512'(1));
      chk("t1_probe_hit",   512'(probe_hit), 512'(1));
      t = 0;
      while (!bready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("t1_probe_wait_b", 512'(probe_hit), 512'(1));
      wait_idle();
      chk("t1_probe_after_b", 512'(probe_hit), 512'(0));
      @(posedge clk);
      #1;

      // AW backpressure with alternating wready: W finishes first
      aw_stall_cfg = 6;
      w_alt        = 1'b1;
      push_line(56'h8000_2057, rand_line());
      wait_idle();
      chk("t2_w_before_aw", 512'(w_first_seen), 512'(1));
      aw_stall_cfg = 0;
      w_alt        = 1'b0;
      @(posedge clk);
      #1;

      // fill the FIFO, third push blocks until the first B
      b_delay  = 6;
      b_before = b_count;
      probe_paddr = 56'h8000_3000;
      push_line(56'h8000_3000, rand_line());
      push_line(56'h8000_3040, rand_line());
      @(negedge clk);
      chk("t3_full_ready", 512'(wb_req_ready), 512'(0));
      @(posedge clk);
      #1;
      push_line(56'h8000_3081, rand_line());
      wait_idle();
      chk("t3_b_count", 512'(b_count - b_before), 512'(3));
      b_delay = 3;
      @(posedge clk);
      #1;

      // error response on the first line, clean response on the second
      b_resp_cfg = 2'b10;
      push_line(56'h8000_4000, rand_line());
      push_line(56'h8000_4040, rand_line());
      wait_b_hs();
      b_resp_cfg = 2'b00;
      wait_idle();
`ifdef L1D_WB_BRESP_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      chk("t4_wb_err_sticky", 512'(wb_err), 512'(exp_err));
      @(posedge clk);
      #1;

      // reset in the middle of a burst, after beat 0
      aw_stall_cfg = 20;
      push_line(56'h8000_5000, rand_line());
      t = 0;
      @(negedge clk);
      while (!(wvalid && wready) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("t5_beat0_timeout", 512'(1), 512'(0));
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_awvalid",   512'(awvalid),      512'(0));
      chk("t5_rst_wvalid",    512'(wvalid),       512'(0));
      chk("t5_rst_bready",    512'(bready),       512'(0));
      chk("t5_rst_busy",      512'(wb_busy),      512'(0));
      chk("t5_rst_req_ready", 512'(wb_req_ready), 512'(1));
      chk("t5_rst_err",       512'(wb_err),       512'(0));
      aw_stall_cfg = 0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (awvalid || wvalid) stray++;
      end
      chk("t5_no_stale", 512'(stray), 512'(0));
      @(posedge clk);
      #1;
      push_line(56'h8000_6040, rand_line());
      wait_idle();

      chk("sb_empty", 512'(aw_q.size() + w_q.size()), 512'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
